// File: rtl/vad_pregate_buffer.sv
// Pre-roll audio gate behind the VAD: records continuously into a circular buffer,
// replays recent history on onset, streams live audio, then flushes on speech end.
module vad_pregate_buffer #(
    parameter int DATA_W          = 16,
    parameter int ADDR_W          = 13,
    parameter int PREROLL_SAMPLES = 4800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] audio_in,
    input  logic              sample_valid,
    input  logic              pre_trigger_pulse,
    input  logic              speech_detected,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              utt_done,
    output logic              gate_active,
    output logic              overrun,
    output logic [ADDR_W:0]   fill_level
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef logic [ADDR_W:0] ptr_t;
    localparam ptr_t              FULL_OCC = ptr_t'(DEPTH - 1);
    localparam ptr_t              PREROLL  = ptr_t'(PREROLL_SAMPLES);
    localparam ptr_t              PTR_ONE  = ptr_t'(1);
    localparam logic [ADDR_W-1:0] TW_MAX   = '1;
    localparam logic [ADDR_W-1:0] TW_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // rd_ptr counts accepted samples (drives occupancy); f_ptr is the next RAM fetch.
    ptr_t              wr_ptr, rd_ptr, f_ptr, end_ptr, od_ptr, sk_ptr;
    logic [ADDR_W-1:0] tw;
    logic              pending, sd_q, fall_p, sv;
    logic [DATA_W-1:0] sk_data;

    ptr_t              wr_next, tw_ext, start_ptr, occ;
    logic [ADDR_W-1:0] tw_next;
    logic [DATA_W-1:0] rd_word;
    logic              acc, fetch, avail, drop, capture, done, fall_seen;

    assign wr_next   = wr_ptr + ptr_t'(sample_valid);
    assign tw_next   = (sample_valid && tw != TW_MAX) ? tw + TW_ONE : tw;
    assign tw_ext    = {1'b0, tw_next};
    assign start_ptr = wr_next - ((tw_ext < PREROLL) ? tw_ext : PREROLL);
    assign occ       = wr_ptr - rd_ptr;
    assign acc       = out_valid && out_ready;
    assign fall_seen = fall_p && !speech_detected;
    assign rd_word   = mem[f_ptr[ADDR_W-1:0]];
    // A fetch always has a landing slot: the output register or the skid entry.
    assign fetch     = avail && (!sv || acc);
    assign drop      = (state_q != IDLE) && sample_valid && (occ == FULL_OCC) && !acc;
    // Tagging at the output (not at fetch) also catches samples fetched before the end was known.
    assign out_last  = (state_q == FLUSH) && out_valid && (od_ptr + PTR_ONE == end_ptr);

    always_comb begin
        state_d = state_q;
        avail   = 1'b0;
        capture = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (pre_trigger_pulse) state_d = STREAM;
            STREAM: begin
                avail = (f_ptr != wr_ptr);
                if (fall_seen) begin
                    capture = 1'b1;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                avail = (f_ptr != end_ptr);
                done  = (acc && out_last) || (!out_valid && rd_ptr == end_ptr);
                if (done) state_d = (pending || pre_trigger_pulse) ? STREAM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign utt_done    = done;
    assign gate_active = (state_q != IDLE);
    assign fill_level  = (state_q == IDLE) ? '0 : occ;

    always_ff @(posedge clk) begin
        if (sample_valid) mem[wr_ptr[ADDR_W-1:0]] <= audio_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            f_ptr     <= '0;
            end_ptr   <= '0;
            od_ptr    <= '0;
            sk_ptr    <= '0;
            tw        <= '0;
            pending   <= 1'b0;
            sd_q      <= 1'b0;
            fall_p    <= 1'b0;
            sv        <= 1'b0;
            sk_data   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_ptr  <= wr_next;
            tw      <= tw_next;
            sd_q    <= speech_detected;
            fall_p  <= sd_q && !speech_detected;
            if (drop)    overrun <= 1'b1;
            if (capture) end_ptr <= wr_next;
            if (state_q == FLUSH && pre_trigger_pulse) pending <= 1'b1;
            if (done) pending <= 1'b0;

            if (state_q == IDLE) begin
                rd_ptr <= pre_trigger_pulse ? start_ptr : wr_next;
                f_ptr  <= pre_trigger_pulse ? start_ptr : wr_next;
            end else begin
                rd_ptr <= rd_ptr + ptr_t'(acc) + ptr_t'(drop);
                f_ptr  <= f_ptr + ptr_t'(fetch) + ptr_t'(drop);
            end

            if (acc && sv) begin
                out_data <= sk_data;
                od_ptr   <= sk_ptr;
                sv       <= fetch;
                if (fetch) begin
                    sk_data <= rd_word;
                    sk_ptr  <= f_ptr;
                end
            end else if (acc || !out_valid) begin
                out_valid <= fetch;
                if (fetch) begin
                    out_data <= rd_word;
                    od_ptr   <= f_ptr;
                end
            end else if (fetch) begin
                sk_data <= rd_word;
                sk_ptr  <= f_ptr;
                sv      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vad_pregate_buffer.sv
// Directed bench for vad_pregate_buffer with a 16-deep buffer and 8-sample pre-roll.
module tb_vad_pregate_buffer;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int PR = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] audio_in;
    logic          sample_valid, pre_trigger_pulse, speech_detected;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready, out_last, utt_done, gate_active, overrun;
    logic [AW:0]   fill_level;

    vad_pregate_buffer #(.DATA_W(DW), .ADDR_W(AW), .PREROLL_SAMPLES(PR)) dut (
        .clk(clk), .rst_n(rst_n), .audio_in(audio_in), .sample_valid(sample_valid),
        .pre_trigger_pulse(pre_trigger_pulse), .speech_detected(speech_detected),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .utt_done(utt_done), .gate_active(gate_active),
        .overrun(overrun), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            utt_cnt = 0;
    logic [DW-1:0] got[$];
    logic          lst[$];
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                lst.push_back(out_last);
            end
            if (utt_done) utt_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] v);
        audio_in     = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic trig();
        pre_trigger_pulse = 1'b1;
        tick();
        pre_trigger_pulse = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        pre_trigger_pulse = 1'b0;
        speech_detected = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        got.delete();
        lst.delete();
        exp_q.delete();
        utt_cnt = 0;
    endtask

    task automatic wait_n(input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) tick();
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        audio_in = '0;
        do_reset();

        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_utt", utt_done, 0);
        chk("rst_gate", gate_active, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_fill", fill_level, 0);

        // Test 1: 20 samples, trigger replays the last 8 (13..20)
        for (int i = 1; i <= 20; i++) wr(DW'(i));
        trig();
        chk("t1_valid_c1", out_valid, 0);
        tick();
        chk("t1_valid_c2", out_valid, 1);
        chk("t1_first", out_data, 13);
        wait_n(8, 30);
        tick();
        for (int i = 13; i <= 20; i++) exp_q.push_back(DW'(i));
        chk_stream("t1_seq");
        chk("t1_fill", fill_level, 0);
        chk("t1_gate", gate_active, 1);

        // Test 3: live 21..24, speech falls with 24 -> last on 24, one utt_done
        wr(21); wr(22); wr(23);
        audio_in = 24; sample_valid = 1'b1; speech_detected = 1'b0;
        tick();
        sample_valid = 1'b0;
        repeat (8) tick();
        for (int i = 21; i <= 24; i++) exp_q.push_back(DW'(i));
        chk_stream("t3_seq");
        for (int i = 0; i < lst.size(); i++) chk("t3_last", lst[i], (i == 11));
        chk("t3_utt", utt_cnt, 1);
        chk("t3_gate", gate_active, 0);
        chk("t3_fill", fill_level, 0);

        // Test 2: only three samples of history
        do_reset();
        wr(5); wr(6); wr(7);
        trig();
        repeat (8) tick();
        exp_q = '{16'd5, 16'd6, 16'd7};
        chk_stream("t2_seq");
        chk("t2_fill", fill_level, 0);
        chk("t2_gate", gate_active, 1);

        // Test 4: stalled consumer, buffer saturates at 15 and drops oldest unread
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) wr(DW'(i));
        trig();
        tick();
        chk("t4_head", out_data, 1);
        for (int i = 9; i <= 15; i++) wr(DW'(i));
        chk("t4_fill_full", fill_level, 15);
        chk("t4_no_ovr", overrun, 0);
        for (int i = 16; i <= 18; i++) wr(DW'(i));
        chk("t4_fill_sat", fill_level, 15);
        chk("t4_ovr", overrun, 1);
        chk("t4_stable_v", out_valid, 1);
        chk("t4_stable_d", out_data, 1);
        out_ready = 1'b1;
        wait_n(15, 40);
        repeat (4) tick();
        exp_q = '{16'd1, 16'd2};
        for (int i = 6; i <= 18; i++) exp_q.push_back(DW'(i));
        chk_stream("t4_seq");
        chk("t4_ovr_sticky", overrun, 1);

        // Test 5: out_ready toggles 1010 over a 40-sample stream
        do_reset();
        for (int i = 0; i < 4; i++) wr(DW'(100 + i));
        trig();
        n = 4;
        for (int t = 0; t < 400 && got.size() < 40; t++) begin
            out_ready = (t % 2 == 0);
            if (n < 40 && t % 3 == 0) begin
                audio_in = DW'(100 + n);
                sample_valid = 1'b1;
                n++;
            end else begin
                sample_valid = 1'b0;
            end
            tick();
        end
        sample_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 40; i++) exp_q.push_back(DW'(100 + i));
        chk_stream("t5_seq");
        chk("t5_ovr", overrun, 0);

        // Test 6: trigger during FLUSH continues from end_ptr, then reset mid-stream
        do_reset();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(DW'(i));
        trig();
        tick();
        tick();
        speech_detected = 1'b0;
        tick();
        tick();
        chk("t6_gate_flush", gate_active, 1);
        trig();
        for (int i = 0; i < 5; i++) wr(DW'(50 + i));
        speech_detected = 1'b1;
        out_ready = 1'b1;
        wait_n(9, 40);
        repeat (2) tick();
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        for (int i = 0; i < 5; i++) exp_q.push_back(DW'(50 + i));
        chk_stream("t6_seq");
        for (int i = 0; i < lst.size(); i++) chk("t6_last", lst[i], (i == 3));
        chk("t6_utt", utt_cnt, 1);
        chk("t6_gate_stream", gate_active, 1);
        chk("t6_fill", fill_level, 0);

        out_ready = 1'b0;
        wr(60); wr(61);
        tick();
        chk("t6_pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_last", out_last, 0);
        chk("t6_rst_utt", utt_done, 0);
        chk("t6_rst_gate", gate_active, 0);
        chk("t6_rst_fill", fill_level, 0);
        chk("t6_rst_ovr", overrun, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_no_utt", utt_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vad_pregate_buffer.md
Name: vad_pregate_buffer

Overview:
- Sits directly downstream of the VAD. It consumes the same 16 kHz PCM stream the VAD sees, plus the VAD's pre_trigger_pulse and speech_detected outputs.
- It continuously records audio into a circular buffer.
- On pre-trigger it replays the last PREROLL_SAMPLES samples, so speech onset is not clipped, then streams live samples to a valid/ready consumer (feature extractor).
- When speech_detected falls it flushes the remaining queued samples and marks the end of the utterance.

Parameters:
- DATA_W, 16, PCM sample width.
- ADDR_W, 13, buffer address width; DEPTH = 2^ADDR_W = 8192 samples.
- PREROLL_SAMPLES, 4800, history replayed on trigger (300 ms @ 16 kHz). Must be < DEPTH-1.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- audio_in  in  DATA_W  PCM sample, two's complement
- sample_valid  in  1  one-cycle strobe, audio_in valid
- pre_trigger_pulse  in  1  one-cycle VAD onset pulse
- speech_detected  in  1  VAD decision including hangover
- out_data  out  DATA_W  gated sample
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid&out_ready
- out_last  out  1  qualifies the final sample of an utterance
- utt_done  out  1  one-cycle pulse when an utterance burst completes
- gate_active  out  1  high in STREAM or FLUSH
- overrun  out  1  sticky, oldest unread sample was dropped
- fill_level  out  ADDR_W+1  unread occupancy wr_ptr-rd_ptr (0 in IDLE)

Behaviour:
Reset:
- All outputs are 0. Pointers, written-sample count, end_ptr and pending flag clear. State is IDLE. Buffer contents are don't-care.

Writes (every state):
- On sample_valid, mem[wr_ptr] <= audio_in and wr_ptr increments modulo DEPTH.
- total_written saturates at DEPTH-1.

Pointers and arithmetic:
- ADDR_W+1-bit pointers; wrap is natural modulo.
- occupancy = wr_ptr - rd_ptr, unsigned.

State IDLE:
- rd_ptr tracks wr_ptr. out_valid=0.
- On pre_trigger_pulse, set rd_ptr = wr_next - min(total_written_next, PREROLL_SAMPLES).
  - wr_next and total_written_next include any sample written in the same cycle.
- Go to STREAM.

State STREAM:
- Emit samples while occupancy>0, advancing rd_ptr on each accept.
- Memory read is synchronous (1 cycle). A registered output stage with a 1-entry skid keeps throughput at 1 sample/cycle under out_ready toggling.
- First out_valid is exactly 2 cycles after pre_trigger_pulse when out_ready=1.
- pre_trigger_pulse is ignored in this state.
- On speech_detected 1->0 (registered edge detect):
  - capture end_ptr = wr_next.
  - go to FLUSH.

State FLUSH:
- Emit until the sample at end_ptr-1 has been accepted. out_last=1 on that sample only.
- On completion: utt_done pulses for 1 cycle, then go to IDLE.
- If a pre_trigger_pulse arrives during FLUSH:
  - set pending.
  - on completion go straight to STREAM, with rd_ptr continuing from end_ptr (no gap, no re-replay).
  - utt_done still pulses.
- If occupancy==0 at capture, no sample is emitted; utt_done pulses the cycle after capture.

Overrun:
- Condition: occupancy==DEPTH-1, a write occurs, and no accept occurs that cycle.
- Action: rd_ptr advances by 1 (oldest dropped) and overrun sets, sticky until reset.
- The in-flight output register keeps its sample; the dropped sample is the next unread one.

Handshake:
- out_data and out_last are held stable while out_valid && !out_ready.
- out_valid never deasserts without an accept, except at reset.

Reset mid-burst:
- Asynchronously returns everything to the reset state. No utt_done is generated.

Simultaneous events:
- pre_trigger_pulse and a speech_detected fall in the same cycle in IDLE: take the trigger. The fall is then seen one cycle later only if speech_detected is still low, which makes a zero-length STREAM followed by FLUSH.
- Write and accept in the same cycle leave occupancy unchanged.

Test Plan:
- Bench parameters: ADDR_W=4, PREROLL_SAMPLES=8, out_ready=1 unless stated.
1. After reset, write samples 1..20, pulse pre_trigger -> out_data sequence 13..20 (8 samples), first out_valid 2 cycles after the pulse, fill_level then 0.
2. Only 3 samples (5,6,7) written before trigger -> replay exactly 5,6,7, no stale data.
3. After trigger, write 21..24, drop speech_detected after 24 -> stream ends at 24 with out_last=1 only on 24, utt_done one pulse, gate_active=0, fill_level=0.
4. Hold out_ready=0 through replay while writing 10 more samples -> occupancy stops at 15, overrun=1, oldest dropped, remaining order contiguous and monotonic, out_data stable while stalled.
5. Toggle out_ready 1010... during a 40-sample stream -> all 40 samples delivered once, in order, no duplicates.
6. pre_trigger during FLUSH, then 5 new samples -> after utt_done, streaming continues from end_ptr with no gap; assert rst_n low mid-stream -> all outputs 0 immediately, no utt_done.
